hskbus_rx_arbiter: RTL and testbench
====================================

HSKBUS_RX_ARBITER -- requirements
Module: hskbus_rx_arbiter

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 160: clk_i cycles per UART bit (80 MHz, 500 kbps).
REQ-002 SHALL have parameter IDLE_BITS, default 20: line-high bit times that end a packet.
REQ-003 SHALL have parameter RESP_TIMEOUT, default 80000: clk_i cycles allowed for a response to start (1 ms).
REQ-004 SHALL have port clk_i  in  1: single clock for all logic.
REQ-005 SHALL have port rst_n_i  in  1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port hskbus_tx_i  in  1: host UART transmit, async, idle high.
REQ-007 SHALL have port surf_rx_i  in  1: SURF responder UART, async, idle high.
REQ-008 SHALL have port hski2c_rx_i  in  1: hski2c responder UART, async, idle high.
REQ-009 SHALL have port crate_enable_i  in  1: SURF path enable, static or slow.
REQ-010 SHALL have port hskbus_rx_o  out  1: arbitrated return line to host.
REQ-011 SHALL have port surf_tx_o  out  1: hskbus_tx_i when crate_enable_i=1, else 1 (combinational).
REQ-012 SHALL have port hski2c_tx_o  out  1: hskbus_tx_i (combinational).
REQ-013 SHALL have port grant_o  out  2: one-hot grant; bit0 = hski2c, bit1 = SURF, 00 = none.
REQ-014 SHALL have port resp_bytes_o  out  8: start-bit count of the current/last response.
REQ-015 SHALL have port timeout_o  out  1: one-cycle pulse on response timeout.
REQ-016 SHALL have port collision_o  out  1: one-cycle pulse when the host restarts during a response.

Function
REQ-017 SHALL pass hskbus_tx_i, surf_rx_i and hski2c_rx_i each through a 2-FF synchronizer, reset value 1; all edge detection uses synchronized values.
REQ-018 SHALL define a start edge as synchronized value 1 -> 0 on consecutive cycles.
REQ-019 SHALL implement states IDLE, HOST_TX, WAIT_RESP, RESP.
REQ-020 IDLE: grant_o=00, hskbus_rx_o=1; host start edge -> HOST_TX.
REQ-021 HOST_TX: an idle counter reloads to IDLE_BITS*CLKS_PER_BIT on every cycle the synchronized host line is low; otherwise it decrements; on reaching 0 -> WAIT_RESP and the response timer loads RESP_TIMEOUT.
REQ-022 WAIT_RESP: hskbus_rx_o=1, and the response timer decrements each cycle.
REQ-023 WAIT_RESP: hski2c start edge -> RESP with grant 01; SURF start edge with crate_enable_i=1 -> RESP with grant 10; simultaneous edges -> hski2c wins.
REQ-024 WAIT_RESP: SURF edges SHALL be ignored while crate_enable_i=0.
REQ-025 WAIT_RESP: host start edge -> HOST_TX, taking priority over responder edges in the same cycle.
REQ-026 WAIT_RESP: timer reaching 0 with no edge -> IDLE, with timeout_o=1 for exactly that cycle.
REQ-027 On entry to RESP: resp_bytes_o SHALL be set to 1, and a holdoff counter SHALL load (19*CLKS_PER_BIT)/2 (1520 at default).
REQ-028 RESP: granted source start edge while holdoff=0 -> resp_bytes_o increments (wraps 255->0) and holdoff reloads.
REQ-029 RESP: start edges while holdoff != 0 SHALL neither count nor reload.
REQ-030 RESP: hskbus_rx_o = synchronized granted source; the ungranted source SHALL be ignored.
REQ-031 RESP: the idle counter SHALL track the granted source per REQ-021; on expiry -> IDLE, grant cleared.
REQ-032 RESP: host start edge -> HOST_TX, grant cleared, collision_o=1 for one cycle.
REQ-033 RESP: crate_enable_i=0 while grant=10 -> IDLE on next cycle, hskbus_rx_o=1.
REQ-034 resp_bytes_o SHALL hold its value outside RESP until the next RESP entry.
REQ-035 hskbus_rx_o SHALL be registered; latency from granted input pin to hskbus_rx_o is 3 cycles.

Reset
REQ-036 While rst_n_i=0: state IDLE, hskbus_rx_o=1, grant_o=00, resp_bytes_o=0, timeout_o=0, collision_o=0, all counters 0, synchronizers 1.
REQ-037 Reset asserted mid-packet SHALL abort immediately; after release the block waits in IDLE for a fresh host start edge.

Verification
REQ-038 Host sends 3 bytes, then line high 3200 cycles -> WAIT_RESP; hski2c sends 4 bytes -> grant_o=01, resp_bytes_o=4, IDLE 3200 cycles after last stop bit.
REQ-039 crate_enable_i=1, SURF and hski2c start edges in the same cycle -> grant_o=01; SURF activity never appears on hskbus_rx_o.
REQ-040 crate_enable_i=0, SURF-only response -> no grant, timeout_o pulses once 80000 cycles after WAIT_RESP entry, surf_tx_o held 1.
REQ-041 During a SURF response, host start edge -> collision_o pulses once, grant_o=00, state HOST_TX.
REQ-042 Glitch low on granted source 800 cycles after a start edge -> resp_bytes_o unchanged; valid edge at 1600 cycles -> increments.
REQ-043 rst_n_i low for 1 cycle during RESP -> all outputs at REQ-036 values asynchronously; 256 bytes afterward -> resp_bytes_o wraps to 0.

Source files
------------

// File: rtl/hskbus_rx_arbiter.sv
// Return-path arbiter for the housekeeping UART bus: after a host packet it grants the
// first responder (hski2c or SURF) to start, counts its bytes and times out silent responders.
module hskbus_rx_arbiter #(
   parameter int unsigned CLKS_PER_BIT = 160,
   parameter int unsigned IDLE_BITS    = 20,
   parameter int unsigned RESP_TIMEOUT = 80000
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       hskbus_tx_i,
   input  logic       surf_rx_i,
   input  logic       hski2c_rx_i,
   input  logic       crate_enable_i,
   output logic       hskbus_rx_o,
   output logic       surf_tx_o,
   output logic       hski2c_tx_o,
   output logic [1:0] grant_o,
   output logic [7:0] resp_bytes_o,
   output logic       timeout_o,
   output logic       collision_o
);

   localparam int unsigned IDLE_LOAD = IDLE_BITS * CLKS_PER_BIT;
   localparam int unsigned HOLD_LOAD = (19 * CLKS_PER_BIT) / 2;
   localparam int unsigned IW = $clog2(IDLE_LOAD + 1);
   localparam int unsigned TW = $clog2(RESP_TIMEOUT + 1);
   localparam int unsigned HW = $clog2(HOLD_LOAD + 1);
   localparam logic [IW-1:0] IDLE_LD = IW'(IDLE_LOAD);
   localparam logic [TW-1:0] TMR_LD  = TW'(RESP_TIMEOUT);
   localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_LOAD);

   typedef enum logic [1:0] {S_IDLE, S_HOST_TX, S_WAIT_RESP, S_RESP} state_t;

   state_t        state;
   // Line index: 0 = host, 1 = hski2c, 2 = SURF
   logic [2:0]    sync1, sync2, sync_q;
   logic [2:0]    fall;
   logic [IW-1:0] idle_cnt;
   logic [TW-1:0] resp_tmr;
   logic [HW-1:0] holdoff;
   logic          src_s, src_fall;

   assign surf_tx_o   = crate_enable_i ? hskbus_tx_i : 1'b1;
   assign hski2c_tx_o = hskbus_tx_i;

   assign fall     = sync_q & ~sync2;
   assign src_s    = grant_o[1] ? sync2[2] : sync2[1];
   assign src_fall = grant_o[1] ? fall[2]  : fall[1];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state        <= S_IDLE;
         sync1        <= '1;
         sync2        <= '1;
         sync_q       <= '1;
         idle_cnt     <= '0;
         resp_tmr     <= '0;
         holdoff      <= '0;
         hskbus_rx_o  <= 1'b1;
         grant_o      <= '0;
         resp_bytes_o <= '0;
         timeout_o    <= 1'b0;
         collision_o  <= 1'b0;
      end else begin
         sync1       <= {surf_rx_i, hski2c_rx_i, hskbus_tx_i};
         sync2       <= sync1;
         sync_q      <= sync2;
         timeout_o   <= 1'b0;
         collision_o <= 1'b0;
         case (state)
            S_IDLE: begin
               hskbus_rx_o <= 1'b1;
               grant_o     <= '0;
               if (fall[0]) begin
                  state    <= S_HOST_TX;
                  idle_cnt <= IDLE_LD;
               end
            end
            S_HOST_TX: begin
               hskbus_rx_o <= 1'b1;
               if (!sync2[0]) begin
                  idle_cnt <= IDLE_LD;
               end else if (idle_cnt < IW'(2)) begin
                  state    <= S_WAIT_RESP;
                  idle_cnt <= '0;
                  resp_tmr <= TMR_LD;
               end else begin
                  idle_cnt <= idle_cnt - 1'b1;
               end
            end
            S_WAIT_RESP: begin
               hskbus_rx_o <= 1'b1;
               if (fall[0]) begin
                  state    <= S_HOST_TX;
                  idle_cnt <= IDLE_LD;
               end else if (fall[1] || (fall[2] && crate_enable_i)) begin
                  // hski2c wins a same-cycle tie; the granted line is low on entry
                  state        <= S_RESP;
                  grant_o      <= fall[1] ? 2'b01 : 2'b10;
                  hskbus_rx_o  <= 1'b0;
                  resp_bytes_o <= 8'd1;
                  holdoff      <= HOLD_LD;
                  idle_cnt     <= IDLE_LD;
               end else if (resp_tmr < TW'(2)) begin
                  state     <= S_IDLE;
                  resp_tmr  <= '0;
                  timeout_o <= 1'b1;
               end else begin
                  resp_tmr <= resp_tmr - 1'b1;
               end
            end
            S_RESP: begin
               if (fall[0]) begin
                  state       <= S_HOST_TX;
                  grant_o     <= '0;
                  hskbus_rx_o <= 1'b1;
                  collision_o <= 1'b1;
                  idle_cnt    <= IDLE_LD;
                  holdoff     <= '0;
               end else if (grant_o[1] && !crate_enable_i) begin
                  state       <= S_IDLE;
                  grant_o     <= '0;
                  hskbus_rx_o <= 1'b1;
               end else begin
                  hskbus_rx_o <= src_s;
                  // Edges inside the holdoff window are data bits, not new start bits
                  if (src_fall && holdoff == '0) begin
                     resp_bytes_o <= resp_bytes_o + 8'd1;
                     holdoff      <= HOLD_LD;
                  end else if (holdoff != '0) begin
                     holdoff <= holdoff - 1'b1;
                  end
                  if (!src_s) begin
                     idle_cnt <= IDLE_LD;
                  end else if (idle_cnt < IW'(2)) begin
                     state       <= S_IDLE;
                     grant_o     <= '0;
                     hskbus_rx_o <= 1'b1;
                     idle_cnt    <= '0;
                  end else begin
                     idle_cnt <= idle_cnt - 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hskbus_rx_arbiter.sv
// Directed/randomized bench for hskbus_rx_arbiter with reduced timing parameters;
// expectations come from byte counts, line history and timing arithmetic.
module tb_hskbus_rx_arbiter;

   localparam int unsigned CPB    = 16;
   localparam int unsigned IB     = 20;
   localparam int unsigned RT     = 2000;
   localparam int unsigned IDLE_N = IB * CPB;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic       host = 1'b1, surf = 1'b1, i2c = 1'b1, en = 1'b1;
   logic       rx_o, surf_tx, i2c_tx, timeout_o, collision_o;
   logic [1:0] grant;
   logic [7:0] resp_bytes;

   int n_cmp = 0, n_err = 0, cyc = 0;
   int tmo_cnt = 0, tmo_cyc = -1, col_cnt = 0, col_cyc = -1;
   int last_rise [3];
   int wait_entry, t0, a, tc0, cc0, nb, src;
   bit chk_rx = 1'b0;
   int chk_line = 1;
   logic [2:0] hist [3];

   hskbus_rx_arbiter #(.CLKS_PER_BIT(CPB), .IDLE_BITS(IB), .RESP_TIMEOUT(RT)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .hskbus_tx_i(host), .surf_rx_i(surf),
      .hski2c_rx_i(i2c), .crate_enable_i(en), .hskbus_rx_o(rx_o),
      .surf_tx_o(surf_tx), .hski2c_tx_o(i2c_tx), .grant_o(grant),
      .resp_bytes_o(resp_bytes), .timeout_o(timeout_o), .collision_o(collision_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Returned line must equal the granted pin as it stood three clocks earlier
   always @(posedge clk) begin
      cyc++;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = {surf, i2c, host};
      #1;
      if (timeout_o)   begin tmo_cnt++; tmo_cyc = cyc; end
      if (collision_o) begin col_cnt++; col_cyc = cyc; end
      if (chk_rx && rst_n) check("rx_follow", 32'(rx_o), 32'(hist[2][chk_line]));
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) tick();
   endtask

   task automatic drive(input int line, input logic v);
      case (line)
         0: begin if (!host && v) last_rise[0] = cyc + 1; host = v; end
         1: begin if (!i2c  && v) last_rise[1] = cyc + 1; i2c  = v; end
         default: begin if (!surf && v) last_rise[2] = cyc + 1; surf = v; end
      endcase
   endtask

   // mask bit0 = host, bit1 = hski2c, bit2 = SURF; 8N1 frames, LSB first, bit-aligned
   task automatic send_frame(input logic [2:0] mask, input logic [7:0] dh,
                             input logic [7:0] di, input logic [7:0] ds);
      logic [7:0] d [3];
      logic v;
      d[0] = dh; d[1] = di; d[2] = ds;
      for (int b = 0; b < 10; b++) begin
         for (int l = 0; l < 3; l++) begin
            if (mask[l]) begin
               v = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : d[l][b-1];
               drive(l, v);
            end
         end
         #1;
         check("i2c_tx_pass", 32'(i2c_tx), 32'(host));
         check("surf_tx_pass", 32'(surf_tx), 32'(en ? host : 1'b1));
         tick(CPB);
      end
   endtask

   task automatic host_packet(input int n);
      for (int k = 0; k < n; k++) send_frame(3'b001, 8'($urandom), 8'h00, 8'h00);
      wait_entry = last_rise[0] + IDLE_N + 1;
   endtask

   initial begin
      for (int l = 0; l < 3; l++) begin last_rise[l] = 0; hist[l] = '1; end
      // Reset values
      tick(3);
      check("rst_rx", 32'(rx_o), 32'd1);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_bytes", 32'(resp_bytes), 32'd0);
      check("rst_timeout", 32'(timeout_o), 32'd0);
      check("rst_collision", 32'(collision_o), 32'd0);
      rst_n = 1'b1;
      tick(3);

      // Host 3 bytes, hski2c answers with 4 bytes
      tc0 = tmo_cnt;
      host_packet(3);
      wait_until(wait_entry + 30);
      chk_line = 1; chk_rx = 1'b1;
      send_frame(3'b010, 8'h00, 8'($urandom), 8'h00);
      check("a_grant", 32'(grant), 32'd1);
      for (int k = 0; k < 3; k++) send_frame(3'b010, 8'h00, 8'($urandom), 8'h00);
      check("a_bytes", 32'(resp_bytes), 32'd4);
      a = last_rise[1];
      wait_until(a + IDLE_N);
      check("a_grant_before_idle", 32'(grant), 32'd1);
      tick();
      check("a_grant_idle", 32'(grant), 32'd0);
      check("a_rx_idle", 32'(rx_o), 32'd1);
      check("a_bytes_hold", 32'(resp_bytes), 32'd4);
      check("a_no_timeout", 32'(tmo_cnt), 32'(tc0));
      chk_rx = 1'b0;

      // Simultaneous SURF and hski2c starts: hski2c wins, SURF never reaches host
      host_packet(1);
      wait_until(wait_entry + 30);
      chk_line = 1; chk_rx = 1'b1;
      t0 = $urandom;
      send_frame(3'b110, 8'h00, 8'(t0), ~8'(t0));
      check("b_grant", 32'(grant), 32'd1);
      t0 = $urandom;
      send_frame(3'b110, 8'h00, 8'(t0), ~8'(t0));
      check("b_bytes", 32'(resp_bytes), 32'd2);
      wait_until(last_rise[1] + IDLE_N + 2);
      check("b_grant_idle", 32'(grant), 32'd0);
      chk_rx = 1'b0;

      // SURF disabled: SURF-only reply is ignored and the response times out
      en = 1'b0;
      tc0 = tmo_cnt;
      host_packet(1);
      wait_until(wait_entry + 40);
      send_frame(3'b100, 8'h00, 8'h00, 8'($urandom));
      check("c_grant0", 32'(grant), 32'd0);
      send_frame(3'b100, 8'h00, 8'h00, 8'($urandom));
      check("c_grant1", 32'(grant), 32'd0);
      wait_until(wait_entry + RT + 3);
      check("c_tmo_count", 32'(tmo_cnt), 32'(tc0 + 1));
      check("c_tmo_time", 32'(tmo_cyc), 32'(wait_entry + RT));
      check("c_rx", 32'(rx_o), 32'd1);
      en = 1'b1;

      // Host restarts during a SURF response
      host_packet(1);
      wait_until(wait_entry + 30);
      chk_line = 2; chk_rx = 1'b1;
      send_frame(3'b100, 8'h00, 8'h00, 8'($urandom));
      check("d_grant", 32'(grant), 32'd2);
      check("d_bytes", 32'(resp_bytes), 32'd1);
      chk_rx = 1'b0;
      cc0 = col_cnt;
      tc0 = tmo_cnt;
      drive(0, 1'b0);
      t0 = cyc + 3;
      tick(6);
      check("d_col_count", 32'(col_cnt), 32'(cc0 + 1));
      check("d_col_time", 32'(col_cyc), 32'(t0));
      check("d_grant0", 32'(grant), 32'd0);
      check("d_rx", 32'(rx_o), 32'd1);
      tick(CPB - 6);
      drive(0, 1'b1);
      wait_entry = last_rise[0] + IDLE_N + 1;
      wait_until(wait_entry + RT + 2);
      check("d_hosttx_tmo", 32'(tmo_cyc), 32'(wait_entry + RT));
      check("d_tmo_count", 32'(tmo_cnt), 32'(tc0 + 1));

      // SURF grant dropped when crate is disabled mid-response
      host_packet(1);
      wait_until(wait_entry + 30);
      send_frame(3'b100, 8'h00, 8'h00, 8'($urandom));
      check("e_grant", 32'(grant), 32'd2);
      en = 1'b0;
      tick();
      check("e_grant0", 32'(grant), 32'd0);
      check("e_rx", 32'(rx_o), 32'd1);
      en = 1'b1;
      tick(IDLE_N);

      // Glitch inside holdoff is not counted; a later start bit is
      host_packet(1);
      wait_until(wait_entry + 30);
      chk_line = 1; chk_rx = 1'b1;
      drive(1, 1'b0);
      t0 = cyc;
      tick(CPB);
      drive(1, 1'b1);
      wait_until(t0 + 5 * CPB);
      drive(1, 1'b0);
      tick(3);
      drive(1, 1'b1);
      tick(6);
      check("f_glitch_bytes", 32'(resp_bytes), 32'd1);
      check("f_grant", 32'(grant), 32'd1);
      wait_until(t0 + 10 * CPB);
      drive(1, 1'b0);
      tick(CPB);
      drive(1, 1'b1);
      tick(4);
      check("f_valid_bytes", 32'(resp_bytes), 32'd2);
      wait_until(last_rise[1] + IDLE_N + 2);
      check("f_grant_idle", 32'(grant), 32'd0);
      chk_rx = 1'b0;

      // Randomized responder/length rounds
      for (int r = 0; r < 4; r++) begin
         src = ($urandom_range(0, 1) == 0) ? 1 : 2;
         nb  = int'($urandom_range(1, 5));
         host_packet(int'($urandom_range(1, 3)));
         wait_until(wait_entry + int'($urandom_range(10, 200)));
         chk_line = src; chk_rx = 1'b1;
         for (int k = 0; k < nb; k++)
            send_frame(src == 1 ? 3'b010 : 3'b100, 8'h00, 8'($urandom), 8'($urandom));
         check("r_grant", 32'(grant), 32'(src == 1 ? 1 : 2));
         check("r_bytes", 32'(resp_bytes), 32'(nb));
         wait_until(last_rise[src] + IDLE_N + 2);
         check("r_grant_idle", 32'(grant), 32'd0);
         check("r_bytes_hold", 32'(resp_bytes), 32'(nb));
         chk_rx = 1'b0;
      end

      // Reset during a response, then a 256-byte response wraps the count
      host_packet(1);
      wait_until(wait_entry + 30);
      send_frame(3'b010, 8'h00, 8'($urandom), 8'h00);
      send_frame(3'b010, 8'h00, 8'($urandom), 8'h00);
      check("g_grant", 32'(grant), 32'd1);
      drive(1, 1'b0);
      tick(4);
      rst_n = 1'b0;
      #1;
      check("g_rst_rx", 32'(rx_o), 32'd1);
      check("g_rst_grant", 32'(grant), 32'd0);
      check("g_rst_bytes", 32'(resp_bytes), 32'd0);
      check("g_rst_tmo", 32'(timeout_o), 32'd0);
      check("g_rst_col", 32'(collision_o), 32'd0);
      tick();
      rst_n = 1'b1;
      drive(1, 1'b1);
      tick(5);
      send_frame(3'b010, 8'h00, 8'($urandom), 8'h00);
      check("g_idle_ignores", 32'(grant), 32'd0);
      check("g_idle_bytes", 32'(resp_bytes), 32'd0);
      host_packet(1);
      wait_until(wait_entry + 30);
      chk_line = 1; chk_rx = 1'b1;
      for (int k = 0; k < 255; k++) send_frame(3'b010, 8'h00, 8'($urandom), 8'h00);
      check("g_bytes255", 32'(resp_bytes), 32'd255);
      send_frame(3'b010, 8'h00, 8'($urandom), 8'h00);
      check("g_bytes_wrap", 32'(resp_bytes), 32'd0);
      check("g_grant_wrap", 32'(grant), 32'd1);
      wait_until(last_rise[1] + IDLE_N + 2);
      check("g_grant_idle", 32'(grant), 32'd0);
      chk_rx = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
